// File: rtl/route_loader.sv
// route_loader: turns add / delete / clear-all route commands into TCAM
// write-port transactions while keeping a shadow of each slot's valid bit,
// canonical prefix and length.
// Optional build macro: ROUTE_LOADER_EARLY_EXIT_EN ends the slot scan on the
// first matching slot instead of always walking the whole table.
module route_loader #(
  parameter int SIZE  = 32,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_prefix,
  input  logic [7:0]           cmd_len,
  input  logic [3:0]           cmd_if,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_status,
  output logic [7:0]           rsp_index,
  output logic                 wr_en,
  output logic [7:0]           wr_index,
  output logic [2*WIDTH+4:0]   wr_data,
  output logic [7:0]           entries_used
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int DW = 2 * WIDTH + 5;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

`ifdef ROUTE_LOADER_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_DEL  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_FULL     = 2'b01;
  localparam logic [1:0] ST_NOTFOUND = 2'b10;
  localparam logic [1:0] ST_BAD      = 2'b11;

  typedef enum logic [2:0] {IDLE, SCAN, WRITE, CLEAR, RESP} state_t;

  // Netmask with len ones from the MSB; len equal to WIDTH gives all ones.
  function automatic logic [WIDTH-1:0] len_mask(input logic [7:0] len);
    len_mask = ~({WIDTH{1'b1}} >> len);
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  prefix_q, prefix_d;
  logic [7:0]        len_q, len_d;
  logic [3:0]        if_q, if_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic              found_match_q, found_match_d;
  logic              found_free_q, found_free_d;
  logic [IW-1:0]     match_idx_q, match_idx_d;
  logic [IW-1:0]     free_idx_q, free_idx_d;
  logic [1:0]        pend_status_q, pend_status_d;
  logic [7:0]        pend_index_q, pend_index_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic [7:0]        rsp_index_q, rsp_index_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_index_q, wr_index_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic [7:0]        entries_q, entries_d;
  logic [SIZE-1:0]   shadow_valid_q, shadow_valid_d;
  logic [WIDTH-1:0]  shadow_prefix_q [SIZE];
  logic [WIDTH-1:0]  shadow_prefix_d [SIZE];
  logic [7:0]        shadow_len_q [SIZE];
  logic [7:0]        shadow_len_d [SIZE];

  logic              cur_match, cur_free, any_match, any_free, scan_last;
  logic [IW-1:0]     hit_idx, free_sel, next_idx;

  // Per-slot scan results, folded with what earlier scan cycles recorded.
  assign cur_match = shadow_valid_q[scan_idx_q] &&
                     (shadow_prefix_q[scan_idx_q] == prefix_q) &&
                     (shadow_len_q[scan_idx_q] == len_q);
  assign cur_free  = !shadow_valid_q[scan_idx_q];
  assign any_match = found_match_q || cur_match;
  assign any_free  = found_free_q || cur_free;
  assign hit_idx   = found_match_q ? match_idx_q : scan_idx_q;
  assign free_sel  = found_free_q ? free_idx_q : scan_idx_q;
  assign next_idx  = scan_idx_q + 1'b1;
  assign scan_last = (scan_idx_q == LAST_IDX) || (EARLY_EXIT && cur_match);

  // Next-state, shadow-table and registered-output computation.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    prefix_d        = prefix_q;
    len_d           = len_q;
    if_d            = if_q;
    scan_idx_d      = scan_idx_q;
    found_match_d   = found_match_q;
    found_free_d    = found_free_q;
    match_idx_d     = match_idx_q;
    free_idx_d      = free_idx_q;
    pend_status_d   = pend_status_q;
    pend_index_d    = pend_index_q;
    entries_d       = entries_q;
    shadow_valid_d  = shadow_valid_q;
    shadow_prefix_d = shadow_prefix_q;
    shadow_len_d    = shadow_len_q;
    rsp_valid_d     = 1'b0;
    rsp_status_d    = 2'b00;
    rsp_index_d     = 8'd0;
    wr_en_d         = 1'b0;
    wr_index_d      = 8'd0;
    wr_data_d       = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d          = cmd_op;
          len_d         = cmd_len;
          if_d          = cmd_if;
          prefix_d      = cmd_prefix & len_mask(cmd_len);
          scan_idx_d    = '0;
          found_match_d = 1'b0;
          found_free_d  = 1'b0;
          if (cmd_op == OP_RSVD || cmd_len > 8'(WIDTH)) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_BAD;
          end else if (cmd_op == OP_CLR) begin
            state_d           = CLEAR;
            wr_en_d           = 1'b1;
            wr_index_d        = 8'd0;
            shadow_valid_d[0] = 1'b0;
          end else begin
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        if (cur_match && !found_match_q) begin
          found_match_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end
        if (cur_free && !found_free_q) begin
          found_free_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
        if (scan_last) begin
          state_d       = WRITE;
          pend_status_d = ST_OK;
          pend_index_d  = 8'd0;
          if (op_q == OP_ADD) begin
            if (any_match) begin
              wr_en_d      = 1'b1;
              wr_index_d   = 8'(hit_idx);
              wr_data_d    = {1'b1, if_q, len_mask(len_q), prefix_q};
              pend_index_d = 8'(hit_idx);
            end else if (any_free) begin
              wr_en_d                   = 1'b1;
              wr_index_d                = 8'(free_sel);
              wr_data_d                 = {1'b1, if_q, len_mask(len_q), prefix_q};
              pend_index_d              = 8'(free_sel);
              shadow_valid_d[free_sel]  = 1'b1;
              shadow_prefix_d[free_sel] = prefix_q;
              shadow_len_d[free_sel]    = len_q;
              if (entries_q != 8'hFF) entries_d = entries_q + 8'd1;
            end else begin
              pend_status_d = ST_FULL;
            end
          end else if (op_q == OP_DEL) begin
            if (any_match) begin
              wr_en_d                 = 1'b1;
              wr_index_d              = 8'(hit_idx);
              pend_index_d            = 8'(hit_idx);
              shadow_valid_d[hit_idx] = 1'b0;
              if (entries_q != 8'd0) entries_d = entries_q - 8'd1;
            end else begin
              pend_status_d = ST_NOTFOUND;
            end
          end
        end else begin
          scan_idx_d = next_idx;
        end
      end

      WRITE: begin
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_status_d = pend_status_q;
        rsp_index_d  = pend_index_q;
      end

      CLEAR: begin
        if (scan_idx_q == LAST_IDX) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          entries_d    = 8'd0;
        end else begin
          scan_idx_d               = next_idx;
          wr_en_d                  = 1'b1;
          wr_index_d               = 8'(next_idx);
          shadow_valid_d[next_idx] = 1'b0;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation but leaves the
  // shadow prefix/length storage untouched since the valid bits gate it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      op_q           <= 2'b00;
      prefix_q       <= '0;
      len_q          <= 8'd0;
      if_q           <= 4'd0;
      scan_idx_q     <= '0;
      found_match_q  <= 1'b0;
      found_free_q   <= 1'b0;
      match_idx_q    <= '0;
      free_idx_q     <= '0;
      pend_status_q  <= 2'b00;
      pend_index_q   <= 8'd0;
      rsp_valid_q    <= 1'b0;
      rsp_status_q   <= 2'b00;
      rsp_index_q    <= 8'd0;
      wr_en_q        <= 1'b0;
      wr_index_q     <= 8'd0;
      wr_data_q      <= '0;
      entries_q      <= 8'd0;
      shadow_valid_q <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      prefix_q        <= prefix_d;
      len_q           <= len_d;
      if_q            <= if_d;
      scan_idx_q      <= scan_idx_d;
      found_match_q   <= found_match_d;
      found_free_q    <= found_free_d;
      match_idx_q     <= match_idx_d;
      free_idx_q      <= free_idx_d;
      pend_status_q   <= pend_status_d;
      pend_index_q    <= pend_index_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_status_q    <= rsp_status_d;
      rsp_index_q     <= rsp_index_d;
      wr_en_q         <= wr_en_d;
      wr_index_q      <= wr_index_d;
      wr_data_q       <= wr_data_d;
      entries_q       <= entries_d;
      shadow_valid_q  <= shadow_valid_d;
      shadow_prefix_q <= shadow_prefix_d;
      shadow_len_q    <= shadow_len_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_status   = rsp_status_q;
  assign rsp_index    = rsp_index_q;
  assign wr_en        = wr_en_q;
  assign wr_index     = wr_index_q;
  assign wr_data      = wr_data_q;
  assign entries_used = entries_q;

endmodule

// File: tb/tb_route_loader.sv
// Scoreboard bench for route_loader: a table-level route model predicts the
// TCAM writes and responses (with their cycle numbers) for every accepted
// command; a monitor on the falling edge pops and compares them.
module tb_route_loader;

  localparam int SIZE = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_prefix;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_if;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [7:0]  rsp_index;
  logic        wr_en;
  logic [7:0]  wr_index;
  logic [68:0] wr_data;
  logic [7:0]  entries_used;

  route_loader #(.SIZE(SIZE), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_prefix(cmd_prefix), .cmd_len(cmd_len), .cmd_if(cmd_if),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_index(rsp_index),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .entries_used(entries_used)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          valid;
    logic [31:0] pfx;
    logic [7:0]  len;
    logic [3:0]  ifx;
  } route_t;

  typedef struct {
    logic [7:0]  idx;
    logic [68:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [1:0] status;
    logic [7:0] idx;
    int         cyc;
    int         used;
  } rsp_t;

  route_t tbl [SIZE];
  wr_t    wr_q [$];
  rsp_t   rsp_q [$];
  int     total = 0;
  int     bad = 0;
  bit     mon_on = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic logic [31:0] maskOf(input int len);
    logic [31:0] m = '0;
    for (int b = 0; b < 32; b++) if (b < len) m[31-b] = 1'b1;
    return m;
  endfunction

  function automatic int usedCount();
    int n = 0;
    for (int i = 0; i < SIZE; i++) if (tbl[i].valid) n++;
    return n;
  endfunction

  function automatic void pushWr(input int idx, input logic [68:0] data, input int c);
    wr_t w;
    w.idx = 8'(idx); w.data = data; w.cyc = c;
    wr_q.push_back(w);
  endfunction

  function automatic void pushRsp(input logic [1:0] st, input int idx, input int c);
    rsp_t r;
    r.status = st; r.idx = 8'(idx); r.cyc = c; r.used = usedCount();
    rsp_q.push_back(r);
  endfunction

  // Route-table model: decides the outcome from the whole table at once.
  function automatic void modelIssue(input logic [1:0] op, input logic [31:0] pfx,
                                     input logic [7:0] len, input logic [3:0] ifx, input int c0);
    logic [31:0] m, cp;
    int hit, fr, done;
    if (op == 2'b11 || len > 32) begin
      pushRsp(2'b11, 0, c0 + 1);
    end else if (op == 2'b10) begin
      for (int i = 0; i < SIZE; i++) begin
        pushWr(i, 69'd0, c0 + 1 + i);
        tbl[i].valid = 1'b0;
      end
      pushRsp(2'b00, 0, c0 + SIZE + 1);
    end else begin
      m = maskOf(int'(len));
      cp = pfx & m;
      hit = -1;
      fr = -1;
      for (int i = 0; i < SIZE; i++) begin
        if (hit < 0 && tbl[i].valid && tbl[i].pfx == cp && tbl[i].len == len) hit = i;
        if (fr < 0 && !tbl[i].valid) fr = i;
      end
      done = c0 + SIZE + 2;
`ifdef ROUTE_LOADER_EARLY_EXIT_EN
      if (hit >= 0) done = c0 + hit + 3;
`endif
      if (op == 2'b00) begin
        if (hit >= 0 || fr >= 0) begin
          int s = (hit >= 0) ? hit : fr;
          tbl[s].valid = 1'b1; tbl[s].pfx = cp; tbl[s].len = len; tbl[s].ifx = ifx;
          pushWr(s, {1'b1, ifx, m, cp}, done - 1);
          pushRsp(2'b00, s, done);
        end else begin
          pushRsp(2'b01, 0, done);
        end
      end else begin
        if (hit >= 0) begin
          tbl[hit].valid = 1'b0;
          pushWr(hit, 69'd0, done - 1);
          pushRsp(2'b00, hit, done);
        end else begin
          pushRsp(2'b10, 0, done);
        end
      end
    end
  endfunction

  // Waits (at falling edges) for cmd_ready, throwing junk at the busy DUT.
  task automatic waitIdle();
    for (int n = 0; n < 300; n++) begin
      if (cmd_ready === 1'b1) begin
        cmd_valid = 1'b0;
        return;
      end
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_op     = 2'($urandom);
      cmd_prefix = $urandom;
      cmd_len    = 8'($urandom);
      cmd_if     = 4'($urandom);
      @(negedge clk);
    end
    total++;
    bad++;
    $display("[TB] FAIL idle_timeout actual=busy required=cmd_ready");
    finishRun();
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] pfx,
                               input logic [7:0] len, input logic [3:0] ifx, output int c0);
    waitIdle();
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_prefix = pfx;
    cmd_len    = len;
    cmd_if     = ifx;
    c0 = cyc;
    modelIssue(op, pfx, len, ifx, c0);
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_op     = 2'($urandom);
    cmd_prefix = $urandom;
    cmd_len    = 8'($urandom);
    cmd_if     = 4'($urandom);
  endtask

  // Monitor: every write and response must match the head of its queue.
  wr_t  mw;
  rsp_t mr;
  always @(negedge clk) begin
    if (mon_on) begin
      if (wr_en === 1'b1) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_write actual=idx %0d required=none", wr_index);
        end else begin
          mw = wr_q.pop_front();
          checkOutput("wr_index", wr_index, mw.idx);
          checkOutput("wr_data", wr_data, mw.data);
          checkOutput("wr_cycle", cyc, mw.cyc);
        end
      end else begin
        checkOutput("idle_wr_index", wr_index, 0);
        checkOutput("idle_wr_data", wr_data, 0);
      end
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_rsp actual=status %0d required=none", rsp_status);
        end else begin
          mr = rsp_q.pop_front();
          checkOutput("rsp_status", rsp_status, mr.status);
          checkOutput("rsp_index", rsp_index, mr.idx);
          checkOutput("rsp_cycle", cyc, mr.cyc);
          checkOutput("entries_used", entries_used, mr.used);
        end
      end
    end
  end

  int c0;
  logic [31:0] p;
  int k;
  int lens [6] = '{0, 8, 16, 16, 24, 32};

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 0; cmd_prefix = 0; cmd_len = 0; cmd_if = 0;
    for (int i = 0; i < SIZE; i++) tbl[i] = '{1'b0, 32'd0, 8'd0, 4'd0};
    repeat (3) @(negedge clk);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_entries", entries_used, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_rsp_status", rsp_status, 0);
    mon_on = 1'b1;

    // Directed: first add, overwrite, bad commands, absent delete.
    applyStimulus(2'b00, 32'h0A010000, 8'd16, 4'd3, c0);
    applyStimulus(2'b00, 32'h0A010203, 8'd16, 4'd5, c0);
    applyStimulus(2'b00, 32'h0A010203, 8'd33, 4'd1, c0);
    applyStimulus(2'b11, 32'h0B000000, 8'd8, 4'd1, c0);
    applyStimulus(2'b01, 32'hC0A80000, 8'd16, 4'd0, c0);

    // Fill the table, overflow it, then free slot 7 and refill it.
    for (int i = 0; i < SIZE - 1; i++)
      applyStimulus(2'b00, {8'd20, 8'(i), 8'd0, 8'($urandom)}, 8'd24, 4'($urandom), c0);
    applyStimulus(2'b00, 32'h1E000000, 8'd8, 4'd2, c0);
    applyStimulus(2'b01, tbl[7].pfx, tbl[7].len, 4'd0, c0);
    applyStimulus(2'b00, 32'h1F000000, 8'd8, 4'd9, c0);

    // Randomized mix, deletes often aimed at live routes with host bits set.
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 99);
      if (k < 45) begin
        p = {8'd10, 8'($urandom_range(0, 3)), 16'($urandom)};
        applyStimulus(2'b00, p, 8'(lens[$urandom_range(0, 5)]), 4'($urandom), c0);
      end else if (k < 85) begin
        int s = $urandom_range(0, SIZE - 1);
        if (tbl[s].valid && k < 70)
          applyStimulus(2'b01, tbl[s].pfx | (~maskOf(int'(tbl[s].len)) & $urandom),
                        tbl[s].len, 4'($urandom), c0);
        else
          applyStimulus(2'b01, {8'd10, 8'($urandom_range(0, 3)), 16'($urandom)},
                        8'(lens[$urandom_range(0, 5)]), 4'($urandom), c0);
      end else if (k < 92) begin
        applyStimulus(2'($urandom_range(0, 1)), $urandom, 8'($urandom_range(33, 255)), 4'd0, c0);
      end else if (k < 96) begin
        applyStimulus(2'b11, $urandom, 8'd8, 4'd0, c0);
      end else begin
        applyStimulus(2'b10, $urandom, 8'd0, 4'd0, c0);
      end
    end

    // Clear-all, a few adds, then a clear aborted by reset in cycle 10.
    applyStimulus(2'b10, 32'd0, 8'd0, 4'd0, c0);
    applyStimulus(2'b00, 32'h0A020000, 8'd16, 4'd1, c0);
    applyStimulus(2'b00, 32'h0A030000, 8'd16, 4'd2, c0);
    applyStimulus(2'b10, 32'd0, 8'd0, 4'd0, c0);
    while (cyc < c0 + 10) @(negedge clk);
    rst = 1'b1;
    while (wr_q.size() > 0 && wr_q[$].cyc > c0 + 10) void'(wr_q.pop_back());
    while (rsp_q.size() > 0 && rsp_q[$].cyc > c0 + 10) void'(rsp_q.pop_back());
    for (int i = 0; i < SIZE; i++) tbl[i].valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_cmd_ready", cmd_ready, 1);
    checkOutput("abort_wr_en", wr_en, 0);
    checkOutput("abort_entries", entries_used, 0);

    // Table must behave as empty after the aborted clear.
    applyStimulus(2'b00, 32'h0A040000, 8'd16, 4'd7, c0);
    applyStimulus(2'b01, 32'h0A040000, 8'd16, 4'd0, c0);

    waitIdle();
    for (int n = 0; n < 100 && (wr_q.size() > 0 || rsp_q.size() > 0); n++) @(negedge clk);
    checkOutput("pending_writes", wr_q.size(), 0);
    checkOutput("pending_rsps", rsp_q.size(), 0);
    finishRun();
  end

endmodule
